// File: rtl/sipo_frame_receiver_if.sv
// sipo_frame_receiver_if: serial input strobe, parallel valid/ready output and status pulses
// master: drives sin/sin_valid/dout_ready, observes dout, dout_valid, frame_err, overrun, busy (and parity_err)
// slave: the receiver side of the same signals
// SIPO_PARITY_EN adds the parity_err pulse
interface sipo_frame_receiver_if #(parameter int WIDTH = 8);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overrun;
    logic             busy;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
    modport master (output sin, sin_valid, dout_ready,
                    input dout, dout_valid, frame_err, overrun, busy, parity_err);
    modport slave  (input sin, sin_valid, dout_ready,
                    output dout, dout_valid, frame_err, overrun, busy, parity_err);
`else
    modport master (output sin, sin_valid, dout_ready,
                    input dout, dout_valid, frame_err, overrun, busy);
    modport slave  (input sin, sin_valid, dout_ready,
                    output dout, dout_valid, frame_err, overrun, busy);
`endif
endinterface

// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: start bit, WIDTH data bits LSB first, stop bit -> parallel word on a one-entry valid/ready register
// clk: rising-edge clock; reset_n: asynchronous active-low reset
// bus (slave): sin/sin_valid in, dout/dout_valid/dout_ready out handshake, frame_err/overrun pulses, busy
// SIPO_PARITY_EN: even-parity bit between data and stop, adds parity_err pulse
module sipo_frame_receiver #(parameter int WIDTH = 8) (
    input logic clk,
    input logic reset_n,
    sipo_frame_receiver_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, DATA, STOP, PARITY} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_err;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             par_bad;
    logic             parity_err;
    assign bus.parity_err = parity_err;
`endif
    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
    assign bus.busy       = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
            // a load at the stop edge below overrides this consume
            if (dout_valid && bus.dout_ready)
                dout_valid <= 1'b0;
            if (bus.sin_valid) begin
                case (state)
                    IDLE: if (!bus.sin) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                    DATA: begin
                        shreg <= {bus.sin, shreg[WIDTH-1:1]};
                        cnt   <= cnt + CW'(1);
`ifdef SIPO_PARITY_EN
                        if (cnt == CW'(WIDTH - 1)) state <= PARITY;
`else
                        if (cnt == CW'(WIDTH - 1)) state <= STOP;
`endif
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        par_bad <= ^{shreg, bus.sin};
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        if (!bus.sin)
                            frame_err <= 1'b1;
`ifdef SIPO_PARITY_EN
                        else if (par_bad)
                            parity_err <= 1'b1;
`endif
                        else if (!dout_valid || bus.dout_ready) begin
                            dout       <= shreg;
                            dout_valid <= 1'b1;
                        end else
                            overrun <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver: randomized frame stimulus checked against a frame-level model of the holding register
module tb_sipo_frame_receiver;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_dout = '0;
    sipo_frame_receiver_if #(.WIDTH(W)) bus ();
    sipo_frame_receiver #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input logic efe, input logic eov, input logic epe, input logic eb);
        check("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
        check("dout", 32'(bus.dout), 32'(exp_dout));
        check("frame_err", 32'(bus.frame_err), 32'(efe));
        check("overrun", 32'(bus.overrun), 32'(eov));
        check("busy", 32'(bus.busy), 32'(eb));
`ifdef SIPO_PARITY_EN
        check("parity_err", 32'(bus.parity_err), 32'(epe));
`else
        if (epe) check("parity_err_unexpected", 32'(epe), 32'(0));
`endif
    endtask

    // ev: 0 no frame end, 1 good stop, 2 stop bit 0, 3 parity mismatch
    task automatic step(input logic v, input logic b, input logic rdy, input int ev,
                        input logic [W-1:0] w, input logic eb);
        logic efe, eov, epe;
        efe = 1'b0; eov = 1'b0; epe = 1'b0;
        bus.sin_valid = v;
        bus.sin = b;
        bus.dout_ready = rdy;
        if (ev == 1) begin
            if (!exp_valid || rdy) begin
                exp_dout = w;
                exp_valid = 1'b1;
            end else eov = 1'b1;
        end else begin
            if (exp_valid && rdy) exp_valid = 1'b0;
            efe = ev == 2;
            epe = ev == 3;
        end
        @(posedge clk);
        #1;
        check_outputs(efe, eov, epe, eb);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop, input logic par_ok,
                              input int max_gap, input logic rdy_body, input logic rdy_stop);
        logic bits[$];
        logic in_frame;
        int ev;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef SIPO_PARITY_EN
        bits.push_back(par_ok ? ^w : ~^w);
`endif
        in_frame = 1'b0;
        foreach (bits[i]) begin
            repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'($urandom), rdy_body, 0, w, in_frame);
            step(1'b1, bits[i], rdy_body, 0, w, 1'b1);
            in_frame = 1'b1;
        end
        repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'($urandom), rdy_body, 0, w, 1'b1);
        ev = !stop ? 2 : (!par_ok ? 3 : 1);
        step(1'b1, stop, rdy_stop, ev, w, 1'b0);
    endtask

    initial begin
        logic [W-1:0] w;
        logic         par_ok;
        bus.sin = 1'b0;
        bus.sin_valid = 1'b0;
        bus.dout_ready = 1'b0;
        #3;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        send_frame(8'h9A, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, '0, 1'b0);
        send_frame(8'h9A, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, '0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 0, '0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0, 0, '0, 1'b1);
        #2;
        reset_n = 1'b0;
        bus.sin_valid = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_dout = '0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'hFF, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, '0, 1'b0);
`ifdef SIPO_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`endif
        for (int n = 0; n < 30; n++) begin
            w = W'($urandom);
            par_ok = 1'b1;
`ifdef SIPO_PARITY_EN
            par_ok = $urandom_range(5, 0) != 0;
`endif
            send_frame(w, $urandom_range(5, 0) != 0, par_ok, 2, 1'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) step(1'b1, 1'b1, 1'($urandom), 0, '0, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
